led_pattern_gen: RTL
====================

// Module: led_pattern_gen
// PURPOSE
//  Upstream stage of the scoring logic. Generates a pseudo-random 3-LED pattern
//  and shows it for a fixed time, then blanks the LEDs. It then opens a timed
//  input window and captures button presses. At the end of each round it emits a
//  one-cycle cmp_valid with the pattern and the captured buttons, which the
//  points/scoring stage consumes. The game runs a fixed number of rounds.
// PARAMETERS
//  SHOW_CYCLES   50_000_000  clk cycles the pattern is shown on led_out (>=1)
//  INPUT_CYCLES  100_000_000 clk cycles of the button-capture window (>=1)
//  ROUNDS        10          rounds per game, 1..15
//  LFSR_SEED     8'hA5       LFSR reset/reload value, non-zero
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  rst        in   1  synchronous reset, active-low
//  start      in   1  one-cycle pulse, begins a game from IDLE or DONE
//  btn        in   3  button levels, active-high, already debounced and synced
//  led_out    out  3  LED drive, active-high
//  pattern    out  3  pattern of the current round, stable from LOAD to next LOAD
//  btn_cap    out  3  buttons captured in the round, valid with cmp_valid
//  cmp_valid  out  1  one-cycle strobe: pattern/btn_cap ready for scoring
//  round      out  4  index of the current round, 0-based
//  busy       out  1  high in every state except IDLE and DONE
//  game_over  out  1  high in DONE
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, lfsr=LFSR_SEED, all outputs 0.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4. Free-running: shifts every cycle out of
//    reset. If it reaches 0, it reloads LFSR_SEED on the next cycle.
//  FSM (registered; one transition per clk):
//   IDLE : outputs 0; start -> LOAD, round=0.
//   LOAD : 1 cycle. pattern <= lfsr[2:0], or 3'b001 if lfsr[2:0]==0;
//          clear btn_cap and timer -> SHOW.
//   SHOW : led_out=pattern; timer counts; at timer==SHOW_CYCLES-1 -> INPUT, timer=0.
//          Presses during SHOW are ignored.
//   INPUT: led_out=0; rising edge of btn[i] (vs 1-cycle-delayed btn) sets btn_cap[i].
//          btn_cap bits are sticky. Each button counts at most once.
//          An edge in the same cycle as the exit is still captured.
//          At timer==INPUT_CYCLES-1 -> EMIT.
//   EMIT : cmp_valid=1 for exactly this cycle; pattern/btn_cap held.
//          If round==ROUNDS-1 -> DONE, else round++ -> LOAD.
//   DONE : game_over=1, led_out=3'b111, round held; start -> LOAD, round=0.
//  start outside IDLE/DONE is ignored (no restart mid-game).
//  A button held across the SHOW->INPUT boundary does not capture, because it
//    has no rising edge. It must be released and pressed again.
//  Latency: start to first cmp_valid = 1+SHOW_CYCLES+INPUT_CYCLES+1 cycles.
//    Back-to-back rounds are spaced SHOW_CYCLES+INPUT_CYCLES+2 cycles.
//  Timer: single counter, width $clog2(max(SHOW_CYCLES,INPUT_CYCLES)+1).
//    It never wraps, because it is cleared on every state change.
//  Reset mid-game: immediate return to IDLE, all outputs 0, LFSR reseeded.
//    No cmp_valid is produced.
// STRUCTURE
//  Shared package game_pkg: FSM state encoding (IDLE,LOAD,SHOW,INPUT,EMIT,DONE),
//    LED_W=3, ROUND_W=4, LFSR taps constant.
//  One sub-module: lfsr8 (clk, rst, seed, q[7:0]) holding the free-running LFSR
//    and its zero-lockup reload. The FSM, timer and capture stay in this module.
// TESTING (SHOW_CYCLES=4, INPUT_CYCLES=6, ROUNDS=3, LFSR_SEED=8'hA5)
//  1 reset then start at cycle 0:
//    -> led_out==pattern for cycles 2..5, led_out=0 for cycles 6..11;
//       cmp_valid high only at cycle 12, with round==0.
//  2 btn pulse 3'b010 during INPUT, then 3'b001 later in the same window
//    -> btn_cap==3'b011 at cmp_valid. The same btn pulse during SHOW only -> btn_cap==0.
//  3 btn[2] held high from SHOW through INPUT -> btn_cap[2]==0.
//    Release and re-press inside INPUT -> btn_cap[2]==1.
//  4 full game: 3 cmp_valid pulses with round 0,1,2; then game_over=1 and
//    led_out=3'b111. start in DONE -> new game with round=0.
//    start pulsed mid-SHOW -> no effect.
//  5 rst=0 for one cycle during INPUT of round 1 -> next cycle IDLE, all outputs 0,
//    no cmp_valid. The following start replays the same pattern sequence as test 1.
//  6 force the LFSR low bits to zero (or sweep seeds) -> pattern is never 3'b000.
//    The LFSR never sticks at 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the LED pattern game: FSM encoding, widths and
// the LFSR feedback polynomial.
package game_pkg;

  localparam int unsigned LED_W   = 3;
  localparam int unsigned ROUND_W = 4;

  // x^8 + x^6 + x^5 + x^4 + 1, bit i of the mask is stage i+1
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShow,
    StInput,
    StEmit,
    StDone
  } state_e;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

  // An all-zero low slice would light nothing, so it maps to a single LED.
  function automatic logic [LED_W-1:0] pattern_of(input logic [LED_W-1:0] bits);
    return (bits == '0) ? LED_W'(1) : bits;
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Player-facing bundle of the pattern generator: start/buttons in, LEDs and the
// per-round compare record out.
interface led_pattern_gen_if
  import game_pkg::*;
();

  logic               start;
  logic [LED_W-1:0]   btn;
  logic [LED_W-1:0]   led_out;
  logic [LED_W-1:0]   pattern;
  logic [LED_W-1:0]   btn_cap;
  logic               cmp_valid;
  logic [ROUND_W-1:0] round;
  logic               busy;
  logic               game_over;

  modport master (
    output start,
    output btn,
    input  led_out,
    input  pattern,
    input  btn_cap,
    input  cmp_valid,
    input  round,
    input  busy,
    input  game_over
  );

  modport slave (
    input  start,
    input  btn,
    output led_out,
    output pattern,
    output btn_cap,
    output cmp_valid,
    output round,
    output busy,
    output game_over
  );

endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; reloads the seed if it ever reaches zero.
module lfsr8
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = lfsr_step(q_q);
    if (q_q == 8'h00) begin
      q_d = seed;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Round sequencer: shows a pseudo-random LED pattern, opens a timed button
// window, then hands pattern and captured buttons to the scoring stage.
module led_pattern_gen
  import game_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES  = 50_000_000,
  parameter int unsigned INPUT_CYCLES = 100_000_000,
  parameter int unsigned ROUNDS       = 10,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  led_pattern_gen_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (SHOW_CYCLES > INPUT_CYCLES) ? SHOW_CYCLES : INPUT_CYCLES;
  localparam int unsigned TIMER_W    = $clog2(MAX_CYCLES + 1);

  localparam logic [TIMER_W-1:0] SHOW_LAST  = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] INPUT_LAST = TIMER_W'(INPUT_CYCLES - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [LED_W-1:0]   pattern_q, pattern_d;
  logic [LED_W-1:0]   btn_cap_q, btn_cap_d;
  logic [LED_W-1:0]   btn_prev_q;
  logic [LED_W-1:0]   btn_rise;
  logic [7:0]         lfsr_q;
  logic               unused_lfsr;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  // Only the low slice feeds the pattern; the upper stages just keep the sequence long.
  assign unused_lfsr = ^lfsr_q[7:LED_W];

  assign btn_rise = bus.btn & ~btn_prev_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    round_d   = round_q;
    pattern_d = pattern_q;
    btn_cap_d = btn_cap_q;

    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StLoad;
          round_d = '0;
        end
      end

      StLoad: begin
        pattern_d = pattern_of(lfsr_q[LED_W-1:0]);
        btn_cap_d = '0;
        timer_d   = '0;
        state_d   = StShow;
      end

      StShow: begin
        if (timer_q == SHOW_LAST) begin
          timer_d = '0;
          state_d = StInput;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      StInput: begin
        // Capture also on the exit cycle so a last-moment press still counts.
        btn_cap_d = btn_cap_q | btn_rise;
        if (timer_q == INPUT_LAST) begin
          timer_d = '0;
          state_d = StEmit;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      StEmit: begin
        if (round_q == LAST_ROUND) begin
          state_d = StDone;
        end else begin
          round_d = round_q + ROUND_W'(1);
          state_d = StLoad;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      round_q    <= '0;
      pattern_q  <= '0;
      btn_cap_q  <= '0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      round_q    <= round_d;
      pattern_q  <= pattern_d;
      btn_cap_q  <= btn_cap_d;
      btn_prev_q <= bus.btn;
    end
  end

  always_comb begin
    bus.led_out = '0;
    if (state_q == StShow) begin
      bus.led_out = pattern_q;
    end else if (state_q == StDone) begin
      bus.led_out = '1;
    end
  end

  assign bus.pattern   = pattern_q;
  assign bus.btn_cap   = btn_cap_q;
  assign bus.round     = round_q;
  assign bus.cmp_valid = (state_q == StEmit);
  assign bus.busy      = (state_q != StIdle) && (state_q != StDone);
  assign bus.game_over = (state_q == StDone);

endmodule
